// File: rtl/riscv_core_icache_axi_refill.sv
// rtl/riscv_core_icache_axi_refill.sv - I-cache line refill engine issuing one AXI4 INCR read burst per miss
module riscv_core_icache_axi_refill #(
    parameter int ADDR_WIDTH     = 64,
    parameter int LINE_WIDTH     = 256,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      o_mem_done,
    output logic [LINE_WIDTH-1:0]     o_line_data,
    output logic                      o_err,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic [AXI_ID_WIDTH-1:0]   o_arid,
    output logic [2:0]                o_arprot,
    output logic [3:0]                o_arcache,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic [AXI_ID_WIDTH-1:0]   i_rid
);

    localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic              err_acc;
    logic              beat_fire;
    logic              last_beat;
    logic              beat_err;
    logic              err_nxt;
    logic              unused_rresp0;
    logic              unused_addr_lo;

    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_arburst = 2'b01;
    assign o_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign o_arprot  = 3'b100;
    assign o_arcache = 4'b0010;

    assign unused_rresp0  = i_rresp[0];
    assign unused_addr_lo = ^i_addr[OFF_W-1:0];

    // o_rready is high exactly in DATA, so it doubles as the beat-accept qualifier
    assign beat_fire = o_rready & i_rvalid;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign beat_err  = i_rresp[1]
                     | (i_rid != AXI_ID_WIDTH'(AXI_ID))
                     | (i_rlast != last_beat);
    assign err_nxt   = err_acc | (beat_fire & beat_err);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_mem_req) state_nxt = S_ADDR;
            S_ADDR: if (i_arready) state_nxt = S_DATA;
            S_DATA: if (beat_fire && last_beat) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are registered from the next state so they line up with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_arvalid   <= 1'b0;
            o_araddr    <= '0;
            o_rready    <= 1'b0;
            o_mem_done  <= 1'b0;
            o_err       <= 1'b0;
            o_line_data <= '0;
            beat_cnt    <= '0;
            err_acc     <= 1'b0;
        end else begin
            o_arvalid  <= (state_nxt == S_ADDR);
            o_rready   <= (state_nxt == S_DATA);
            o_mem_done <= (state_nxt == S_DONE);
            o_err      <= (state_nxt == S_DONE) & err_nxt;
            if (state == S_IDLE && i_mem_req) begin
                o_araddr <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                beat_cnt <= '0;
                err_acc  <= 1'b0;
            end
            if (beat_fire) begin
                o_line_data[beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                beat_cnt <= beat_cnt + 1'b1;
                err_acc  <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_riscv_core_icache_axi_refill.sv
// tb/tb_riscv_core_icache_axi_refill.sv - directed bench with a line-fill model and per-cycle compare
module tb_riscv_core_icache_axi_refill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_req = 1'b0;
    logic [63:0]  addr = '0;
    logic         mem_done;
    logic [255:0] line_data;
    logic         err;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arid;
    logic [2:0]   arprot;
    logic [3:0]   arcache;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic [3:0]   rid = '0;

    riscv_core_icache_axi_refill dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(mem_req), .i_addr(addr),
        .o_mem_done(mem_done), .o_line_data(line_data), .o_err(err),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr),
        .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst), .o_arid(arid),
        .o_arprot(arprot), .o_arcache(arcache),
        .i_rvalid(rvalid), .o_rready(rready), .i_rdata(rdata), .i_rresp(rresp),
        .i_rlast(rlast), .i_rid(rid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_vec = 0;
    int           n_err = 0;
    int           exp_done = -1;
    int           req_cyc = 0;
    int           last_done = 0;
    logic         last_err = 1'b0;
    logic [63:0]  seen_araddr = '0;
    logic [255:0] model_line = '0;
    logic         exp_arvalid = 1'b0;
    logic         exp_rready = 1'b0;
    logic         exp_err = 1'b0;
    logic [63:0]  exp_araddr = '0;

    int           g_gap [4];
    logic [1:0]   g_resp [4];
    logic [3:0]   g_id [4];
    logic         g_last [4];
    logic [63:0]  g_data [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("mem_done", mem_done, (cyc == exp_done));
        check("err", err, (cyc == exp_done) ? exp_err : 1'b0);
        check("line", line_data, model_line);
        check("arvalid", arvalid, exp_arvalid);
        check("rready", rready, exp_rready);
        if (exp_arvalid) check("araddr", araddr, exp_araddr);
        check("ar_consts", {arlen, arsize, arburst, arid, arprot, arcache},
              {8'd3, 3'd3, 2'b01, 4'd0, 3'b100, 4'b0010});
        if (arvalid) seen_araddr = araddr;
        if (mem_done) begin
            last_done = cyc;
            last_err  = err;
        end
    end

    task automatic set_clean(input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            g_gap[k]  = 0;
            g_resp[k] = 2'b00;
            g_id[k]   = 4'd0;
            g_last[k] = (k == 3);
            g_data[k] = base * 64'(k + 1);
        end
    endtask

    // One line fill driven on a fixed schedule; the model derives araddr, err and done time
    task automatic fill(input logic [63:0] a, input int s, input int abort_beat, input bit junk);
        int g = 0;
        exp_araddr = a & ~64'h1f;
        exp_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g += g_gap[k];
            if (g_resp[k][1] || g_id[k] != 4'd0 || g_last[k] != (k == 3)) exp_err = 1'b1;
        end
        req_cyc  = cyc;
        exp_done = (abort_beat < 0) ? cyc + 2 + s + g + 4 : -1;
        mem_req = 1'b1; addr = a; arready = 1'b0; rvalid = 1'b0;
        @(posedge clk); #1;
        exp_arvalid = 1'b1;
        repeat (s) begin
            arready = 1'b0; rvalid = junk; rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        arready = 1'b1; rvalid = junk;
        @(posedge clk); #1;
        arready = 1'b0; exp_arvalid = 1'b0; exp_rready = 1'b1;
        addr = {$urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            repeat (g_gap[k]) begin
                rvalid = 1'b0; rdata = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            if (k == abort_beat) begin
                rvalid = 1'b1; rdata = g_data[k];
                #1; rst_n = 1'b0; model_line = '0; exp_rready = 1'b0;
                #1;
                check("rst_async_outs", {mem_done, err, arvalid, rready}, 4'b0);
                check("rst_async_line", line_data, 256'd0);
                check("rst_async_araddr", araddr, 64'd0);
                mem_req = 1'b0; rvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1; rst_n = 1'b1;
                return;
            end
            rvalid = 1'b1; rdata = g_data[k]; rresp = g_resp[k]; rid = g_id[k]; rlast = g_last[k];
            @(posedge clk);
            model_line[k*64 +: 64] = g_data[k];
            #1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'd0; exp_rready = 1'b0;
        @(posedge clk); #1;
        mem_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {mem_done, err, arvalid, rready}, 4'b0);
        check("reset_line", line_data, 256'd0);
        check("reset_araddr", araddr, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_clean(64'h1111_1111_1111_1111);
        fill(64'h1000_0034, 0, -1, 1'b0);
        check("t1_araddr", seen_araddr, 64'h1000_0020);
        check("t1_latency", last_done - req_cyc, 6);
        check("t1_line", line_data,
              256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        check("t1_err", last_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        set_clean(64'h0102_0304_0506_0708);
        g_gap[0] = 0; g_gap[1] = 2; g_gap[2] = 1; g_gap[3] = 3;
        fill(64'h0000_0000_8000_00ff, 5, -1, 1'b1);
        check("stall_latency", last_done - req_cyc, 17);
        check("stall_araddr", seen_araddr, 64'h8000_00e0);
        check("stall_line", line_data,
              256'h0408_0c10_1418_1c20_0306_090c_0f12_1518_0204_0608_0a0c_0e10_0102_0304_0506_0708);

        set_clean(64'h0000_0000_0000_abcd);
        g_resp[2] = 2'b10;
        fill(64'h2000, 0, -1, 1'b0);
        check("slverr_flag", last_err, 1'b1);
        check("slverr_latency", last_done - req_cyc, 6);
        set_clean(64'h0000_0000_0000_1234);
        g_resp[1] = 2'b01;
        fill(64'h2040, 0, -1, 1'b0);
        check("clean_after_err", last_err, 1'b0);

        set_clean(64'h55);
        g_last[1] = 1'b1;
        fill(64'h3000, 0, -1, 1'b0);
        check("early_rlast_flag", last_err, 1'b1);
        check("early_rlast_latency", last_done - req_cyc, 6);
        set_clean(64'h66);
        g_id[0] = 4'd5;
        fill(64'h3020, 0, -1, 1'b0);
        check("bad_rid_flag", last_err, 1'b1);
        set_clean(64'h77);
        g_last[3] = 1'b0;
        fill(64'h3040, 0, -1, 1'b0);
        check("missing_rlast_flag", last_err, 1'b1);
        check("missing_rlast_latency", last_done - req_cyc, 6);

        set_clean(64'hdead_beef_0000_0001);
        fill(64'h4000, 0, 2, 1'b0);
        @(posedge clk); #1;
        set_clean(64'h0000_0000_0000_0009);
        fill(64'h4020, 0, -1, 1'b0);
        check("post_reset_latency", last_done - req_cyc, 6);
        check("post_reset_line", line_data,
              256'h0000000000000024_000000000000001b_0000000000000012_0000000000000009);

        set_clean(64'h0a0a_0a0a_0a0a_0a0a);
        fill(64'h5000, 0, -1, 1'b0);
        set_clean(64'h0b0b_0b0b_0b0b_0b0b);
        g_gap[0] = 3;
        fill(64'h5020, 0, -1, 1'b0);
        check("b2b_latency", last_done - req_cyc, 9);
        check("b2b_araddr", seen_araddr, 64'h5020);
        check("b2b_err", last_err, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_core_icache_axi_refill.md
# riscv_core_icache_axi_refill

Refill engine between the instruction-cache controller and the AXI4 interconnect. It accepts a block-aligned line-fill request from the controller, issues a single AXI4 INCR read burst, assembles the returned beats into one cache line, and returns the line with a one-cycle done pulse. The controller holds its request until it sees done. The cache memory writes the line in the controller's update cycle that follows.

## Interface
- ADDR_WIDTH, 64: address width.
- LINE_WIDTH, 256: cache line width in bits.
- AXI_DATA_WIDTH, 64: R channel data width. LINE_WIDTH/AXI_DATA_WIDTH = BEATS (4 at defaults); must be a power of two, at most 256.
- AXI_ID_WIDTH, 4: ID width.
- AXI_ID, 0: constant ARID driven on every request.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_mem_req  in  1  refill request from the cache controller; held high until o_mem_done.
- i_addr  in  ADDR_WIDTH  line address from the cache controller.
- o_mem_done  out  1  one-cycle pulse: line assembled.
- o_line_data  out  LINE_WIDTH  assembled line; beat k occupies bits [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
- o_err  out  1  error for the completed fill; valid while o_mem_done=1.
- o_arvalid / i_arready  out/in  1  AR handshake.
- o_araddr  out  ADDR_WIDTH  burst start address.
- o_arlen  out  8  constant BEATS-1.
- o_arsize  out  3  constant log2(AXI_DATA_WIDTH/8).
- o_arburst  out  2  constant 2'b01 (INCR).
- o_arid  out  AXI_ID_WIDTH  constant AXI_ID.
- o_arprot  out  3  constant 3'b100 (instruction, unprivileged, secure).
- o_arcache  out  4  constant 4'b0010.
- i_rvalid / o_rready  in/out  1  R handshake.
- i_rdata  in  AXI_DATA_WIDTH  read data.
- i_rresp  in  2  read response.
- i_rlast  in  1  last beat.
- i_rid  in  AXI_ID_WIDTH  read ID.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ADDR: AR handshake.
  - DATA: collect beats.
  - DONE: signal completion.
- IDLE -> ADDR on i_mem_req=1.
  - Latch i_addr into o_araddr with the low log2(LINE_WIDTH/8) bits forced to 0.
  - Clear the beat counter and the error accumulator.
- ADDR:
  - o_arvalid=1; o_araddr is held stable.
  - On i_arready=1 -> DATA. o_arvalid drops in the same edge.
- DATA:
  - o_rready=1.
  - Each i_rvalid&o_rready beat writes i_rdata into line slot beat_cnt, then beat_cnt increments.
  - Exit to DONE on the beat where beat_cnt==BEATS-1. o_rready drops in the same edge.
- Error accumulator: set sticky on any accepted beat with any of:
  - i_rresp[1]=1 (SLVERR/DECERR),
  - i_rid != AXI_ID,
  - i_rlast=1 on a non-final beat,
  - i_rlast=0 on the final beat.
- Beat counting always uses beat_cnt, never i_rlast.
- DONE: o_mem_done=1 and o_err = accumulator for exactly one cycle -> IDLE unconditionally.
- o_line_data changes only through beat writes. It stays stable from the final beat until the first beat of the next fill, so the controller's update cycle after done sees the full line.
- i_mem_req is ignored outside IDLE. i_addr is sampled only on the IDLE->ADDR transition.
- i_rvalid is ignored outside DATA (o_rready=0 there).

## Timing
- All outputs are registered.
- Reset values: o_arvalid=0, o_araddr=0, o_rready=0, o_mem_done=0, o_line_data=0, o_err=0; state IDLE.
- The AR constants are combinational ties.
- Minimum latency, with i_arready and i_rvalid tied high (cycle 0 = request sampled high in IDLE):
  - ADDR in cycle 1.
  - Beats in cycles 2..1+BEATS.
  - o_mem_done in cycle 2+BEATS (cycle 6 at defaults).
- After DONE, the earliest next request is accepted in IDLE the following cycle. The controller drops i_mem_req that cycle, so no double fill occurs.
- Stalls: any number of cycles with i_arready=0 or i_rvalid=0 extends ADDR/DATA with no lost or duplicated beat.
- Reset mid-burst:
  - Immediate return to IDLE with all reset values.
  - The outstanding AXI burst is abandoned; the interconnect shares the reset.

## Test plan
- Single fill, i_addr=0x1000_0034, ready/valid tied high -> o_araddr=0x1000_0020, o_arlen=3, o_arsize=3, o_arburst=1; o_mem_done pulse at cycle 6; line = {beat3,beat2,beat1,beat0}; o_err=0.
- i_arready low for 5 cycles, and i_rvalid gaps of 0/2/1/3 cycles between beats:
  - o_araddr is stable while o_arvalid=1.
  - Exactly 4 beats are captured.
  - Done arrives 5+6 cycles later than the back-to-back case.
- Beat 2 returns i_rresp=2'b10 -> all 4 beats accepted; o_err=1 with done; the next clean fill gives o_err=0.
- Protocol faults: i_rlast=1 on beat 1, then a separate fill with i_rid=5 -> each flags o_err=1; done still occurs after exactly 4 beats.
- i_rst_n asserted during beat 2 -> all outputs zero asynchronously; after release, a new request completes normally.
- Back-to-back requests, with i_mem_req re-raised the cycle after done -> the second AR is issued; o_line_data holds line 1 until the second fill's first beat.
